// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: stall/flush control for IF/ID, ID/EX, EX/MEM and PC,
// with an MDU wait timer, sticky timeout flag and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic             use_rs1D,
  input  logic             use_rs2D,
  input  logic [4:0]       rdE,
  input  logic             reg_writeE,
  input  logic             mem_readE,
  input  logic             branch_takenE,
  input  logic             mdu_startE,
  input  logic             mdu_done,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             mdu_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // state     | meaning
  // RUN       | normal flow; rules 3-6 evaluated
  // MDU_WAIT  | multi-cycle MDU op held in EX, timer running
  // DMEM_WAIT | data memory wait seen last cycle; acts as RUN once dmem_ready returns
  typedef enum logic [1:0] {RUN, MDU_WAIT, DMEM_WAIT} state_t;

  localparam int              TW    = $clog2(MDU_TIMEOUT + 1);
  localparam logic [TW-1:0]   T_MAX = TW'(MDU_TIMEOUT);
  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic          load_use, mdu_exit, timed_out, branch_fire;

  assign load_use = mem_readE && reg_writeE && (rdE != 5'd0) &&
                    ((use_rs1D && (rs1D == rdE)) || (use_rs2D && (rs2D == rdE)));
  assign mdu_exit  = (state == MDU_WAIT) && dmem_ready && (mdu_done || (timer == T_MAX));
  assign timed_out = mdu_exit && !mdu_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // An MDU op stays in MDU_WAIT across a data-memory stall; only its timer freezes.
  always_comb begin
    state_nxt = state;
    if (!dmem_ready)
      state_nxt = (state == MDU_WAIT) ? MDU_WAIT : DMEM_WAIT;
    else if (state == MDU_WAIT)
      state_nxt = mdu_exit ? RUN : MDU_WAIT;
    else if (mdu_startE)
      state_nxt = MDU_WAIT;
    else
      state_nxt = RUN;
  end

  always_comb begin
    stallF = 1'b0; stallD = 1'b0; stallE = 1'b0; stallM = 1'b0;
    flushD = 1'b0; flushE = 1'b0; flushM = 1'b0;
    branch_fire = 1'b0;
    if (rst) begin
      flushD = 1'b1; flushE = 1'b1; flushM = 1'b1;
    end else if (!dmem_ready) begin
      stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; stallM = 1'b1;
    end else if (state == MDU_WAIT) begin
      if (!mdu_exit) begin
        stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; flushM = 1'b1;
      end
    end else if (mdu_startE) begin
      stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; flushM = 1'b1;
    end else if (branch_takenE) begin
      flushD = 1'b1; flushE = 1'b1; branch_fire = 1'b1;
    end else if (load_use) begin
      stallF = 1'b1; stallD = 1'b1; flushE = 1'b1;
    end else if (!imem_ready) begin
      stallF = 1'b1; flushD = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (dmem_ready) begin
      if (state != MDU_WAIT && mdu_startE)
        timer <= TW'(1);
      else if (state == MDU_WAIT && timer != T_MAX)
        timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdu_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (timed_out)                       mdu_err   <= 1'b1;
      if (stallF && stall_cnt != C_MAX)    stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_fire && flush_cnt != C_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the priority rules.
module tb_hazard_ctrl;
  localparam int TO   = 64;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] rs1D, rs2D, rdE;
  logic use_rs1D, use_rs2D, reg_writeE, mem_readE, branch_takenE;
  logic mdu_startE, mdu_done, imem_ready, dmem_ready;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, mdu_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0] ctl;
  int total = 0, bad = 0;

  int m_busy, m_wait, m_err, m_sc, m_fc;

  assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushM};

  hazard_ctrl #(.MDU_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D), .use_rs2D(use_rs2D),
    .rdE(rdE), .reg_writeE(reg_writeE), .mem_readE(mem_readE), .branch_takenE(branch_takenE),
    .mdu_startE(mdu_startE), .mdu_done(mdu_done), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .mdu_err(mdu_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  task automatic idle();
    rs1D = 0; rs2D = 0; rdE = 0; use_rs1D = 0; use_rs2D = 0;
    reg_writeE = 0; mem_readE = 0; branch_takenE = 0;
    mdu_startE = 0; mdu_done = 0; imem_ready = 1; dmem_ready = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1; next_cycle(); rst = 0;
  endtask

  // Expected control word {F,D,E,M,fD,fE,fM} from the current inputs and model state.
  function automatic logic [6:0] model_ctl();
    logic hz;
    hz = mem_readE && reg_writeE && rdE != 0 &&
         ((use_rs1D && rs1D == rdE) || (use_rs2D && rs2D == rdE));
    if (!dmem_ready) return 7'b1111000;
    if (m_busy != 0) return (mdu_done || m_wait >= TO) ? 7'b0000000 : 7'b1110001;
    if (mdu_startE) return 7'b1110001;
    if (branch_takenE) return 7'b0000110;
    if (hz) return 7'b1100010;
    if (!imem_ready) return 7'b1000100;
    return 7'b0000000;
  endfunction

  task automatic model_step();
    logic [6:0] c;
    c = model_ctl();
    if (c[6] && m_sc < CMAX) m_sc++;
    if (dmem_ready && m_busy == 0 && !mdu_startE && branch_takenE && m_fc < CMAX) m_fc++;
    if (dmem_ready) begin
      if (m_busy != 0) begin
        if (mdu_done || m_wait >= TO) begin
          if (!mdu_done) m_err = 1;
          m_busy = 0;
        end else m_wait++;
      end else if (mdu_startE) begin
        m_busy = 1; m_wait = 1;
      end
    end
  endtask

  task automatic test_reset();
    idle(); rst = 1; #2;
    total++;
    if (ctl !== 7'b0000111 || stall_cnt !== 0 || flush_cnt !== 0 || mdu_err !== 0) begin
      bad++; $display("FAIL reset ctl=%b sc=%0d fc=%0d err=%b want ctl=0000111 0 0 0", ctl, stall_cnt, flush_cnt, mdu_err);
    end
    next_cycle(); rst = 0;
    @(negedge clk); total++;
    if (ctl !== 7'b0000000) begin bad++; $display("FAIL post_reset ctl=%b want 0000000", ctl); end
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    mem_readE = 1; reg_writeE = 1; rdE = 5; rs1D = 5; rs2D = 1; use_rs1D = 1; use_rs2D = 1;
    @(negedge clk); total++;
    if (ctl !== 7'b1100010) begin bad++; $display("FAIL load_use ctl=%b want 1100010", ctl); end
    next_cycle(); mem_readE = 0; reg_writeE = 0; rdE = 0;
    @(negedge clk); total++;
    if (ctl !== 7'b0000000 || stall_cnt !== 1) begin
      bad++; $display("FAIL load_use_after ctl=%b sc=%0d want 0000000 1", ctl, stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_x0();
    do_reset();
    mem_readE = 1; reg_writeE = 1; rdE = 0; rs1D = 0; rs2D = 0; use_rs1D = 1; use_rs2D = 1;
    @(negedge clk); total++;
    if (ctl !== 7'b0000000) begin bad++; $display("FAIL x0_hazard ctl=%b want 0000000", ctl); end
    next_cycle(); idle();
    @(negedge clk); total++;
    if (stall_cnt !== 0) begin bad++; $display("FAIL x0_cnt sc=%0d want 0", stall_cnt); end
    next_cycle();
  endtask

  task automatic test_branch_over_load_use();
    do_reset();
    mem_readE = 1; reg_writeE = 1; rdE = 7; rs2D = 7; use_rs2D = 1; branch_takenE = 1; imem_ready = 0;
    @(negedge clk); total++;
    if (ctl !== 7'b0000110) begin bad++; $display("FAIL branch_prio ctl=%b want 0000110", ctl); end
    next_cycle(); idle();
    @(negedge clk); total++;
    if (flush_cnt !== 1 || stall_cnt !== 0) begin
      bad++; $display("FAIL branch_cnt fc=%0d sc=%0d want 1 0", flush_cnt, stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_mdu_done();
    do_reset();
    mdu_startE = 1; mdu_done = 1;
    @(negedge clk); total++;
    if (ctl !== 7'b1110001) begin bad++; $display("FAIL mdu_start ctl=%b want 1110001", ctl); end
    next_cycle(); mdu_startE = 0; mdu_done = 0;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk); total++;
      if (ctl !== 7'b1110001) begin bad++; $display("FAIL mdu_wait%0d ctl=%b want 1110001", i, ctl); end
      next_cycle();
    end
    mdu_done = 1;
    @(negedge clk); total++;
    if (ctl !== 7'b0000000) begin bad++; $display("FAIL mdu_exit ctl=%b want 0000000", ctl); end
    next_cycle(); mdu_done = 0;
    @(negedge clk); total++;
    if (ctl !== 7'b0000000 || mdu_err !== 0 || stall_cnt !== 5) begin
      bad++; $display("FAIL mdu_after ctl=%b err=%b sc=%0d want 0000000 0 5", ctl, mdu_err, stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_mdu_timeout();
    int waits;
    do_reset();
    mdu_startE = 1;
    next_cycle(); mdu_startE = 0;
    waits = 0;
    @(negedge clk);
    while (ctl[6] === 1'b1 && waits < 200) begin
      waits++; next_cycle(); @(negedge clk);
    end
    total++;
    if (waits != TO - 1) begin bad++; $display("FAIL mdu_timeout_len got=%0d want %0d", waits, TO - 1); end
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); total++;
      if (mdu_err !== 1 || ctl !== 7'b0000000) begin
        bad++; $display("FAIL mdu_err_sticky%0d err=%b ctl=%b want 1 0000000", i, mdu_err, ctl);
      end
      next_cycle();
    end
    total++;
    if (stall_cnt !== TO) begin bad++; $display("FAIL mdu_timeout_cnt sc=%0d want %0d", stall_cnt, TO); end
    do_reset();
    @(negedge clk); total++;
    if (mdu_err !== 0) begin bad++; $display("FAIL mdu_err_clear err=%b want 0", mdu_err); end
    next_cycle();
  endtask

  task automatic test_dmem_branch();
    do_reset();
    branch_takenE = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); total++;
      if (ctl !== 7'b1111000) begin bad++; $display("FAIL dmem_stall%0d ctl=%b want 1111000", i, ctl); end
      next_cycle();
    end
    dmem_ready = 1;
    @(negedge clk); total++;
    if (ctl !== 7'b0000110) begin bad++; $display("FAIL dmem_release ctl=%b want 0000110", ctl); end
    next_cycle(); idle();
    @(negedge clk); total++;
    if (ctl !== 7'b0000000 || flush_cnt !== 1 || stall_cnt !== 3) begin
      bad++; $display("FAIL dmem_after ctl=%b fc=%0d sc=%0d want 0000000 1 3", ctl, flush_cnt, stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_rst_mid_mdu();
    do_reset();
    mdu_startE = 1; next_cycle(); mdu_startE = 0;
    next_cycle(); next_cycle();
    rst = 1; #2;
    total++;
    if (ctl !== 7'b0000111 || stall_cnt !== 0 || mdu_err !== 0) begin
      bad++; $display("FAIL rst_mid_mdu ctl=%b sc=%0d err=%b want 0000111 0 0", ctl, stall_cnt, mdu_err);
    end
    next_cycle(); rst = 0;
    @(negedge clk); total++;
    if (ctl !== 7'b0000000) begin bad++; $display("FAIL rst_mid_mdu_run ctl=%b want 0000000", ctl); end
    next_cycle();
  endtask

  task automatic test_saturation();
    do_reset();
    imem_ready = 0;
    for (int i = 0; i < 300; i++) next_cycle();
    @(negedge clk); total++;
    if (stall_cnt !== CW'(CMAX) || ctl !== 7'b1000100) begin
      bad++; $display("FAIL stall_sat sc=%0d ctl=%b want %0d 1000100", stall_cnt, ctl, CMAX);
    end
    next_cycle();
    branch_takenE = 1; imem_ready = 1;
    for (int i = 0; i < 260; i++) next_cycle();
    @(negedge clk); total++;
    if (flush_cnt !== CW'(CMAX)) begin bad++; $display("FAIL flush_sat fc=%0d want %0d", flush_cnt, CMAX); end
    next_cycle();
  endtask

  task automatic test_random();
    logic [6:0] exp_ctl;
    do_reset();
    m_busy = 0; m_wait = 0; m_err = 0; m_sc = 0; m_fc = 0;
    for (int n = 0; n < 4000; n++) begin
      rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3)); rdE = 5'($urandom_range(0, 3));
      use_rs1D = 1'($urandom); use_rs2D = 1'($urandom);
      reg_writeE = 1'($urandom); mem_readE = 1'($urandom);
      branch_takenE = ($urandom_range(0, 5) == 0);
      imem_ready = ($urandom_range(0, 4) != 0);
      mdu_startE = (m_busy == 0) && ($urandom_range(0, 15) == 0);
      mdu_done = ($urandom_range(0, 39) == 0);
      dmem_ready = (m_busy != 0) || ($urandom_range(0, 5) != 0);
      @(negedge clk);
      exp_ctl = model_ctl();
      total++;
      if (ctl !== exp_ctl || mdu_err !== 1'(m_err) || stall_cnt !== CW'(m_sc) || flush_cnt !== CW'(m_fc)) begin
        bad++;
        $display("FAIL random n=%0d ctl=%b err=%b sc=%0d fc=%0d want ctl=%b err=%0d sc=%0d fc=%0d",
                 n, ctl, mdu_err, stall_cnt, flush_cnt, exp_ctl, m_err, m_sc, m_fc);
      end
      model_step();
      next_cycle();
    end
  endtask

  initial begin
    idle();
    #1;
    test_reset();
    test_load_use();
    test_x0();
    test_branch_over_load_use();
    test_mdu_done();
    test_mdu_timeout();
    test_dmem_branch();
    test_rst_mid_mdu();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
